emsx_sdram_arbiter: RTL

EMSX_SDRAM_ARBITER -- requirements
Module: emsx_sdram_arbiter

---
 rtl/emsx_sdram_arb_pkg.sv | 25 ++
 rtl/emsx_rr_picker.sv | 28 ++
 rtl/emsx_sdram_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/emsx_sdram_arb_pkg.sv
// Shared types and constants for the EMSX SDRAM arbiter: port geometry,
// FSM state encoding and the round-robin index helper.
package emsx_sdram_arb_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int ADDR_W          = 25;
  localparam int DATA_W          = 8;
  localparam int CNT_W           = 10;
  localparam int TIMEOUT_DEFAULT = 1023;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    DONE
  } state_t;

  // Port index reached by stepping 'offset' places past 'base', wrapping 2 -> 0.
  function automatic port_idx_t wrapIdx(input port_idx_t base, input int offset);
    return port_idx_t'((int'(base) + offset) % NUM_PORTS);
  endfunction

endpackage

// File: rtl/emsx_rr_picker.sv
// Combinational round-robin picker: chooses the first requesting port after
// last_grant_i, wrapping around the port list.
module emsx_rr_picker
  import emsx_sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            last_grant_i,
  output logic                 grant_valid_o,
  output port_idx_t            grant_idx_o
);

  port_idx_t cand;

  // Scan from the farthest port back to the nearest so the closest one wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = last_grant_i;
    cand          = last_grant_i;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      cand = wrapIdx(last_grant_i, off);
      if (req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/emsx_sdram_arbiter.sv
// Three-port round-robin arbiter in front of the EMSX SDRAM controller; one
// transaction at a time with a watchdog that aborts a stalled access.
module emsx_sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = emsx_sdram_arb_pkg::TIMEOUT_DEFAULT,
  parameter int NUM_PORTS      = emsx_sdram_arb_pkg::NUM_PORTS
) (
  input  logic                                      mem_clk,
  input  logic                                      reset_n,
  input  logic                                      sdram_ready,
  input  logic [NUM_PORTS-1:0]                      req,
  input  logic [NUM_PORTS*emsx_sdram_arb_pkg::ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS-1:0]                      req_write,
  input  logic [NUM_PORTS*emsx_sdram_arb_pkg::DATA_W-1:0] req_write_data,
  output logic [NUM_PORTS-1:0]                      ack,
  output logic [emsx_sdram_arb_pkg::DATA_W-1:0]     ack_read_data,
  output logic                                      mem_req,
  input  logic                                      mem_ack,
  output logic [emsx_sdram_arb_pkg::ADDR_W-1:0]     mem_cpu_address,
  output logic                                      mem_cpu_write,
  output logic [emsx_sdram_arb_pkg::DATA_W-1:0]     mem_cpu_write_data,
  input  logic [emsx_sdram_arb_pkg::DATA_W-1:0]     mem_cpu_read_data,
  output logic                                      timeout_err
);

  import emsx_sdram_arb_pkg::*;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q;
  port_idx_t              grant_q;
  port_idx_t              last_grant_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   mem_req_q;
  logic [NUM_PORTS-1:0]   ack_q;
  logic [DATA_W-1:0]      ack_data_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   write_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   timeout_q;

  logic                   pick_valid_d;
  port_idx_t              pick_idx_d;

  emsx_rr_picker u_picker (
    .req_i         (req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (pick_valid_d),
    .grant_idx_o   (pick_idx_d)
  );

  // ack and ack_read_data default to zero every cycle and are loaded only on
  // the edge entering DONE, which makes them a single-cycle pulse.
  always_ff @(posedge mem_clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= port_idx_t'(NUM_PORTS - 1);
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      ack_q        <= '0;
      ack_data_q   <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      ack_q      <= '0;
      ack_data_q <= '0;
      case (state_q)
        IDLE: begin
          if (sdram_ready && pick_valid_d) begin
            grant_q <= pick_idx_d;
            addr_q  <= req_address[int'(pick_idx_d)*ADDR_W +: ADDR_W];
            write_q <= req_write[pick_idx_d];
            wdata_q <= req_write_data[int'(pick_idx_d)*DATA_W +: DATA_W];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mem_req_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            mem_req_q        <= 1'b0;
            ack_q            <= '0;
            ack_q[grant_q]   <= 1'b1;
            ack_data_q       <= mem_cpu_read_data;
            state_q          <= DONE;
          end else if (cnt_q == TO_LAST) begin
            // Stalled controller: release the bus and hand back a poison byte.
            mem_req_q        <= 1'b0;
            timeout_q        <= 1'b1;
            ack_q            <= '0;
            ack_q[grant_q]   <= 1'b1;
            ack_data_q       <= 8'hFF;
            state_q          <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack                = ack_q;
  assign ack_read_data      = ack_data_q;
  assign mem_req            = mem_req_q;
  assign mem_cpu_address    = addr_q;
  assign mem_cpu_write      = write_q;
  assign mem_cpu_write_data = wdata_q;
  assign timeout_err        = timeout_q;

endmodule
